// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned multiply/divide sequencer (MULTU / DIVU).
// The block owns no adder. While an operation runs it drives the shared ALU
// every cycle and folds the ALU result back into HI/LO in that same cycle.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start, op         - request (sampled only in IDLE); op 0 = MULTU, 1 = DIVU
//   src_a, src_b      - multiplicand/dividend, multiplier/divisor
//   busy, done        - operation in progress; one-cycle completion pulse
//   hi, lo            - product[63:32]/remainder, product[31:0]/quotient
//   alu_ctrl_o        - shared ALU operation select
//   alu_a, alu_b      - shared ALU operands
//   alu_res_i         - shared ALU result (combinational, same cycle)
module mdu_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0001,
  parameter logic [3:0] ALU_SUB = 4'b0010,
  parameter logic [3:0] ALU_NOP = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res_i
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [4:0]       count;
  logic             op_r;      // latched operation: 0 = MULTU, 1 = DIVU
  logic [WIDTH-1:0] opnd_r;    // multiplicand M (MULTU) or divisor D (DIVU)

  logic             msb;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic             take;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // ALU drive and next-step datapath; the ALU is only used while in RUN.
  always_comb begin
    alu_ctrl_o = ALU_NOP;
    alu_a      = '0;
    alu_b      = '0;
    msb        = hi[WIDTH-1];
    r_sh       = {hi[WIDTH-2:0], lo[WIDTH-1]};
    if (state == RUN) begin
      if (op_r) begin
        alu_ctrl_o = ALU_SUB;
        alu_a      = r_sh;
        alu_b      = opnd_r;
      end else begin
        alu_ctrl_o = ALU_ADD;
        alu_a      = hi;
        alu_b      = lo[0] ? opnd_r : '0;
      end
    end else begin
      alu_ctrl_o = ALU_NOP;
      alu_a      = '0;
      alu_b      = '0;
    end
    // Carry out of the 32-bit add: the sum wrapped below the addend hi.
    carry  = (alu_res_i < hi);
    // {carry, sum, lo} shifted right by one, low 64 bits kept.
    mul_hi = {carry, alu_res_i[WIDTH-1:1]};
    mul_lo = {alu_res_i[0], lo[WIDTH-1:1]};
    // A set msb means the shifted remainder is 33 bits wide and always >= D.
    take   = msb | (r_sh >= opnd_r);
    div_hi = take ? alu_res_i : r_sh;
    div_lo = {lo[WIDTH-2:0], take};
  end

  // Sequencer FSM with registered busy/done and HI/LO accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= 5'd0;
      op_r   <= 1'b0;
      opnd_r <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r   <= op;
            opnd_r <= src_b;
            count  <= 5'd0;
            busy   <= 1'b1;
            if (op && (src_b == '0)) begin
              // Divide by zero resolves immediately without touching the ALU.
              hi    <= src_a;
              lo    <= '1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              hi    <= '0;
              lo    <= src_a;
              state <= RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          hi    <= op_r ? div_hi : mul_hi;
          lo    <= op_r ? div_lo : mul_lo;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            done  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_ctrl_o(alu_ctrl), .alu_a(alu_a),
    .alu_b(alu_b), .alu_res_i(alu_res)
  );

  always #5 clk = ~clk;

  // Shared ALU the sequencer borrows.
  always_comb begin
    case (alu_ctrl)
      4'b0001: alu_res = alu_a + alu_b;
      4'b0010: alu_res = alu_a - alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          issue;
    int          lat;
    int          adds;
    int          subs;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain 64-bit product and integer divide/modulo.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    if (!o) begin
      p = 64'(a) * 64'(b);
      e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; e.adds = 32; e.subs = 0;
    end else if (b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = 1; e.adds = 0; e.subs = 0;
    end else begin
      e.hi = a % b; e.lo = a / b; e.lat = 33; e.adds = 0; e.subs = 32;
    end
    e.issue = cyc;
    q.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("completion_timeout", 64'(q.size() != 0 || busy), 64'd0);
    @(negedge clk);
    chk("idle_hold_hi", 64'(hi), 64'(last_hi));
    chk("idle_hold_lo", 64'(lo), 64'(last_lo));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'd0);
    chk({tag, "_lo"}, 64'(lo), 64'd0);
    chk({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
  endtask

  // Monitor: counts ALU usage and checks each done pulse against the scoreboard.
  int adds = 0;
  int subs = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        adds = 0;
        subs = 0;
      end else begin
        if (alu_ctrl == 4'b0001) adds++;
        if (alu_ctrl == 4'b0010) subs++;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("latency", 64'(cyc - e.issue), 64'(e.lat));
            chk("add_cycles", 64'(adds), 64'(e.adds));
            chk("sub_cycles", 64'(subs), 64'(e.subs));
            chk("busy_at_done", 64'(busy), 64'd1);
          end
          adds = 0;
          subs = 0;
        end
      end
    end
  end

  initial begin
    int k;
    logic        ro;
    logic [31:0] ra;
    logic [31:0] rb;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue(1'b0, 32'd7, 32'd6);                  wait_idle();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();
    issue(1'b1, 32'd100, 32'd7);                wait_idle();
    issue(1'b1, 32'hFFFF_FFFF, 32'd1);          wait_idle();
    issue(1'b1, 32'h8000_0000, 32'h8000_0001);  wait_idle();
    issue(1'b1, 32'd5, 32'd0);                  wait_idle();
    issue(1'b0, 32'd0, 32'hDEAD_BEEF);          wait_idle();

    // Starts during RUN and during DONE are ignored.
    issue(1'b0, 32'h0001_2345, 32'h0006_789A);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 1'b1; src_a = 32'd99; src_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
    start = 1'b1; op = 1'b0; src_a = 32'd11; src_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_extra_op_busy", 64'(busy), 64'd0);
    wait_idle();

    // Reset in the middle of RUN aborts without a done pulse.
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_reset");
    q.delete();
    last_hi = 32'd0;
    last_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'd3, 32'd3);
    wait_idle();

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative unsigned multiply/divide sequencer for the MIPS core; produces HI/LO for MULTU/DIVU.
- Does not own an adder. Every iteration it drives the shared ALU through an operand/control port and consumes the ALU result in the same cycle.
- Sits beside EX. `busy` is the pipeline stall source for any MFHI/MFLO/MULTU/DIVU issued while an operation runs.

Parameters:
- WIDTH, 32: operand width; matches the ALU, not to be overridden.
- ALU_ADD, 4'b0001: alu_ctrl code for ADD.
- ALU_SUB, 4'b0010: alu_ctrl code for SUB.
- ALU_NOP, 4'b0000: alu_ctrl code driven when idle; the ALU returns 0 for it.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MULTU, 1 = DIVU
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  operation in progress (RUN or DONE)
- done  out  1  one-cycle completion pulse
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_ctrl_o  out  4  to shared ALU alu_ctrl
- alu_a  out  32  to ALU data1
- alu_b  out  32  to ALU data2
- alu_res_i  in  32  from ALU alu_res (combinational, same cycle)

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; hi = lo = 0; count = 0; busy = 0; done = 0.
  - alu_ctrl_o = ALU_NOP; alu_a = alu_b = 0.
  - Reset mid-operation aborts the operation and emits no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1: latch src_a/src_b/op and set count = 0.
  - If op = 1 and src_b = 0, go to DONE; otherwise go to RUN.
  - start while busy is ignored; no queueing.
- MULTU, in RUN:
  - On entry, hi = 0 and lo = src_a; the multiplicand M is held in a register.
  - ALU is driven every cycle with alu_ctrl_o = ALU_ADD, alu_a = hi, alu_b = lo[0] ? M : 0.
  - carry = (alu_res_i < hi), unsigned compare.
  - Next {hi, lo} = {carry, alu_res_i, lo} >> 1, i.e. 65 bits shifted right by 1, low 64 kept.
- DIVU, in RUN (restoring division):
  - On entry, hi = 0 and lo = src_a; the divisor D is held in a register.
  - Each cycle: msb = hi[31]; r_sh = {hi[30:0], lo[31]}.
  - ALU is driven with alu_ctrl_o = ALU_SUB, alu_a = r_sh, alu_b = D.
  - If msb = 1 or r_sh >= D: hi = alu_res_i and lo = {lo[30:0], 1'b1}.
  - Otherwise: hi = r_sh and lo = {lo[30:0], 1'b0}.
- RUN lasts exactly 32 cycles. count increments each cycle; after the cycle with count = 31, go to DONE.
- DONE lasts one cycle: done = 1 and busy = 1, then go to IDLE. A start in the DONE cycle is ignored.
- Divide by zero: no RUN cycles; hi = src_a, lo = 32'hFFFFFFFF; done is asserted in the cycle after start.
- Outside RUN: alu_ctrl_o = ALU_NOP and alu_a = alu_b = 0.
- Latency, with start sampled at edge 0:
  - busy = 1 from edge 0 to edge 33.
  - done = 1 between edges 32 and 33.
  - Divide by zero: done = 1 between edges 0 and 1.
- hi/lo change only in RUN and on the divide-by-zero load. They hold their value after DONE until the next accepted start; in IDLE they always show the last result.
- All arithmetic is modulo 2^32 except the explicit carry bit. No signed operations.
- busy is a registered output (state != IDLE); done is registered.

Test Plan:
- MULTU src_a = 7, src_b = 6 -> done pulses 33 cycles after start; hi = 0, lo = 42; alu_ctrl_o = 4'b0001 for exactly 32 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; exercises the carry path.
- DIVU 100 / 7 -> lo = 14, hi = 2. DIVU 0xFFFFFFFF / 1 -> lo = 0xFFFFFFFF, hi = 0. DIVU 0x80000000 / 0x80000001 -> lo = 0, hi = 0x80000000.
- DIVU 5 / 0 -> done in the cycle after start; hi = 5, lo = 0xFFFFFFFF; no ALU_SUB ever driven.
- Start pulsed at RUN cycle 10 and again in the DONE cycle -> both ignored; the result equals that of the first operation; exactly one done pulse.
- rst_n low at RUN cycle 15 -> all outputs immediately 0 and state IDLE; a following MULTU 3×3 gives lo = 9 with normal 33-cycle timing.
